// File: rtl/uart_transmitter.sv
// uart_transmitter: sends one byte per accepted tx_start as start, 8 data bits LSB first, stop.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the last data bit and the stop bit.
module uart_transmitter #(
    parameter int SAMPLES_PER_BIT = 8,
    parameter int DATA_BITS       = 8
) (
    input  logic       sample_clk,
    input  logic       rstn,
    input  logic [7:0] data_in,
    input  logic       tx_start,
    output logic       serial_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [3:0] SAMPLE_LAST = 4'(SAMPLES_PER_BIT - 1);
    localparam logic [2:0] BIT_LAST    = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STARTING = 3'd1,
        ST_SENDING  = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY   = 3'd3,
`endif
        ST_STOPPING = 3'd4
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] shift_reg, shift_nxt;
    logic [3:0] sample_cnt, sample_cnt_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic       serial_nxt, busy_nxt, done_nxt;
    logic       sample_end;
`ifdef UART_TX_PARITY_EN
    logic       parity_bit, parity_nxt;
`endif

    assign sample_end = (sample_cnt == SAMPLE_LAST);

    always_ff @(posedge sample_clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            shift_reg  <= 8'h00;
            sample_cnt <= 4'd0;
            bit_cnt    <= 3'd0;
            serial_out <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            shift_reg  <= shift_nxt;
            sample_cnt <= sample_cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            serial_out <= serial_nxt;
            tx_busy    <= busy_nxt;
            tx_done    <= done_nxt;
`ifdef UART_TX_PARITY_EN
            parity_bit <= parity_nxt;
`endif
        end
    end

    // Each state computes the registered line level for the next cycle, so bit edges land exactly on counter wrap.
    always_comb begin
        state_nxt      = state;
        shift_nxt      = shift_reg;
        sample_cnt_nxt = sample_cnt;
        bit_cnt_nxt    = bit_cnt;
        serial_nxt     = serial_out;
        busy_nxt       = tx_busy;
        done_nxt       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_nxt     = parity_bit;
`endif
        case (state)
            ST_IDLE: begin
                serial_nxt = 1'b1;
                busy_nxt   = 1'b0;
                if (tx_start) begin
                    state_nxt      = ST_STARTING;
                    shift_nxt      = data_in;
                    sample_cnt_nxt = 4'd0;
                    bit_cnt_nxt    = 3'd0;
                    serial_nxt     = 1'b0;
                    busy_nxt       = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_nxt     = ^data_in;
`endif
                end
            end
            ST_STARTING: begin
                if (sample_end) begin
                    sample_cnt_nxt = 4'd0;
                    serial_nxt     = shift_reg[0];
                    shift_nxt      = {1'b0, shift_reg[7:1]};
                    state_nxt      = ST_SENDING;
                end else begin
                    sample_cnt_nxt = sample_cnt + 4'd1;
                end
            end
            ST_SENDING: begin
                if (sample_end) begin
                    sample_cnt_nxt = 4'd0;
                    if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        serial_nxt = parity_bit;
                        state_nxt  = ST_PARITY;
`else
                        serial_nxt = 1'b1;
                        state_nxt  = ST_STOPPING;
`endif
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        serial_nxt  = shift_reg[0];
                        shift_nxt   = {1'b0, shift_reg[7:1]};
                    end
                end else begin
                    sample_cnt_nxt = sample_cnt + 4'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (sample_end) begin
                    sample_cnt_nxt = 4'd0;
                    serial_nxt     = 1'b1;
                    state_nxt      = ST_STOPPING;
                end else begin
                    sample_cnt_nxt = sample_cnt + 4'd1;
                end
            end
`endif
            ST_STOPPING: begin
                if (sample_end) begin
                    sample_cnt_nxt = 4'd0;
                    serial_nxt     = 1'b1;
                    busy_nxt       = 1'b0;
                    done_nxt       = 1'b1;
                    state_nxt      = ST_IDLE;
                end else begin
                    sample_cnt_nxt = sample_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                serial_nxt = 1'b1;
                busy_nxt   = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serializes one 8-bit byte per request into an asynchronous UART frame: start bit, 8 data bits LSB first, optional parity, stop bit.
- Transmit-side counterpart of the UART receiver. Shares the same sample_clk domain and bit timing, so that sample_clk and SAMPLES_PER_BIT give the line rate.
- Host presents a byte with a single-cycle start strobe and watches tx_busy; line output is idle-high.

Parameters:
- SAMPLES_PER_BIT, 8, sample_clk cycles per transmitted bit. Legal range 2..16; the counter is 4 bits wide.
- DATA_BITS, 8, data bits per frame. Fixed at 8; present for documentation and bit-counter sizing only.

Ports:
- sample_clk  input  1  transmit clock, same clock as the receiver's oversampling clock
- rstn  input  1  asynchronous active-low reset
- data_in  input  8  byte to transmit, sampled only when tx_start is accepted
- tx_start  input  1  request strobe; accepted only when tx_busy=0
- serial_out  output  1  UART line, registered, idle level 1
- tx_busy  output  1  high from the cycle after acceptance through the last stop-bit cycle
- tx_done  output  1  one-cycle pulse in the first cycle after the stop bit completes

Behaviour:
- Clock and reset: one clock, sample_clk. Reset rstn is asynchronous and active-low.
- Reset values:
  - state=idle; shift_reg=8'h00; sample_cnt=0; bit_cnt=0
  - serial_out=1; tx_busy=0; tx_done=0
- Reset mid-frame aborts immediately: serial_out returns to 1 asynchronously and no partial stop bit is emitted.
- States:
  - idle: serial_out=1, tx_busy=0. tx_start=1 at a posedge loads data_in into shift_reg, clears both counters, sets serial_out=0 (start bit) and tx_busy=1, next state starting.
  - starting: hold the start bit. When sample_cnt reaches SAMPLES_PER_BIT-1, clear sample_cnt, drive serial_out=shift_reg[0], shift right, next state sending. Otherwise increment sample_cnt.
  - sending: hold each data bit for SAMPLES_PER_BIT cycles.
    - At each bit boundary: increment bit_cnt, drive the next shift_reg[0], shift right.
    - After D7's boundary, drive serial_out=1 (stop bit) and next state stopping.
  - stopping: hold 1 for SAMPLES_PER_BIT cycles. At the end: next state idle, tx_busy=0, tx_done=1 for exactly one cycle.
  - Illegal or unused state encoding goes to idle with serial_out=1.
- Timing:
  - Latency: start bit appears on serial_out the cycle after tx_start is sampled.
  - Frame length is 10*SAMPLES_PER_BIT cycles (11* with parity); tx_busy is high for exactly that many cycles.
  - Every bit is exactly SAMPLES_PER_BIT cycles, including first and last; no jitter between bits.
- Handshake rules:
  - tx_start while tx_busy=1 is ignored. No queuing; data_in is not sampled.
  - tx_start in the same cycle as tx_done (tx_busy already 0) is accepted. Back-to-back frames are therefore separated only by the stop bit, with no extra idle cycles.
  - data_in may change freely after acceptance; the transmitted byte is the value sampled at acceptance.
- Counters: sample_cnt wraps to 0 at SAMPLES_PER_BIT-1. bit_cnt counts 0..7 and never exceeds DATA_BITS-1; it is cleared on acceptance.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - An even-parity bit is inserted between D7 and the stop bit: serial_out = ^data captured at acceptance.
  - A parity state sits between sending and stopping.
  - Frame is 11 bits; tx_busy is high 11*SAMPLES_PER_BIT cycles.
- When undefined: no parity state or logic; frame is 10 bits, exactly as described above.

Test Plan:
- Reset: assert rstn=0 mid-frame (bit D3) -> serial_out=1, tx_busy=0, tx_done=0 within the same cycle. After release the line stays 1 until a new tx_start.
- Single byte: data_in=8'hA5, tx_start pulse, SAMPLES_PER_BIT=8 -> serial_out sequence 0,1,0,1,0,0,1,0,1,1, each held 8 cycles. tx_busy high 80 cycles; tx_done pulses once at cycle 81.
- Busy rejection: tx_start with data_in=8'hFF at cycle 20 of an 8'h3C frame -> frame continues as 0,0,0,1,1,1,1,0,0,1; no second frame follows.
- Back-to-back: 8'h00 then 8'hFF, the second tx_start coincident with tx_done -> start bit of 8'hFF begins the cycle after the first stop bit ends. Line low for 72 contiguous cycles (start + 8 zeros), then 1 for the stop bit.
- Timing sweep: SAMPLES_PER_BIT=2 and 16 with data_in=8'h81 -> every bit width measures exactly 2 / 16 cycles; frame lengths 20 / 160.
- Parity (UART_TX_PARITY_EN): 8'hA5 -> parity bit 0; 8'h07 -> parity bit 1. 11-bit frames, tx_busy 88 cycles at SAMPLES_PER_BIT=8.
